// File: rtl/bcd_scan_pkg.sv
// Shared constants for the multiplexed BCD display.
// Segment patterns are active-low with segments a..g on bits 0..6.
package bcd_scan_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;
    localparam seg_t SEG_ONE   = 7'b1111001;
    localparam seg_t SEG_TWO   = 7'b0100100;
    localparam seg_t SEG_THREE = 7'b0110000;
    localparam seg_t SEG_FOUR  = 7'b0011001;
    localparam seg_t SEG_FIVE  = 7'b0010010;
    localparam seg_t SEG_SIX   = 7'b0000010;
    localparam seg_t SEG_SEVEN = 7'b1111000;
    localparam seg_t SEG_EIGHT = 7'b0000000;
    localparam seg_t SEG_NINE  = 7'b0010000;

    // Wide enough for the largest supported digit count; sliced to NDIG at the use site.
    localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 decode to blank.
module bcd7seg_dec
    import bcd_scan_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg_n = SEG_ZERO;
            4'd1:    o_seg_n = SEG_ONE;
            4'd2:    o_seg_n = SEG_TWO;
            4'd3:    o_seg_n = SEG_THREE;
            4'd4:    o_seg_n = SEG_FOUR;
            4'd5:    o_seg_n = SEG_FIVE;
            4'd6:    o_seg_n = SEG_SIX;
            4'd7:    o_seg_n = SEG_SEVEN;
            4'd8:    o_seg_n = SEG_EIGHT;
            4'd9:    o_seg_n = SEG_NINE;
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed BCD display scanner with a one-deep pending buffer swapped in at frame boundaries.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_display
    import bcd_scan_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIG_CYC   = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    input  logic [NDIG-1:0]   in_dp,
    output logic [6:0]        seg_n,
    output logic              dp_n,
    output logic [NDIG-1:0]   an_n,
    output logic              frame_start
);

    localparam int PW = $clog2(DIG_CYC);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic              r_pend;
    logic [4*NDIG-1:0] r_pend_bcd;
    logic [NDIG-1:0]   r_pend_dp;
    logic [4*NDIG-1:0] r_disp_bcd;
    logic [NDIG-1:0]   r_disp_dp;
    logic [6:0]        r_seg_n;
    logic              r_dp_n;
    logic [NDIG-1:0]   r_an_n;
    logic              r_frame_start;

    logic              w_presc_wrap;
    logic              w_idx_wrap;
    logic              w_slot0_start;
    logic              w_blank;
    logic [3:0]        w_codes [NDIG];
    logic [3:0]        w_sel_code;
    logic [6:0]        w_dec_seg_n;
    logic [NDIG-1:0]   w_an_sel_n;
    logic              w_lz_sel;

    assign w_presc_wrap  = (r_presc == PW'(DIG_CYC - 1));
    assign w_idx_wrap    = (r_idx == IW'(NDIG - 1));
    assign w_slot0_start = (r_presc == '0) && (r_idx == '0);
    assign w_blank       = (r_presc < PW'(BLANK_CYC));
    assign in_ready      = !r_pend;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            assign w_codes[gi]    = r_disp_bcd[4*gi +: 4];
            assign w_an_sel_n[gi] = (r_idx != IW'(gi));
        end
    endgenerate

    assign w_sel_code = w_codes[r_idx];

    bcd7seg_dec u_dec (
        .i_code  (w_sel_code),
        .o_seg_n (w_dec_seg_n)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // w_lz[i] is set when digit i and every digit above it are zero.
    logic [NDIG-1:0] w_lz;

    always_comb begin : p_lz
        logic v_run;
        v_run = 1'b1;
        w_lz  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            v_run   = v_run && (w_codes[i] == 4'd0);
            w_lz[i] = v_run;
        end
    end

    assign w_lz_sel = (r_idx != '0) && w_lz[r_idx];
`else
    assign w_lz_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_idx   <= w_idx_wrap ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // The display register only changes as the digit 0 slot begins, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_disp_bcd <= '0;
            r_disp_dp  <= '0;
        end else if (w_slot0_start && r_pend) begin
            r_disp_bcd <= r_pend_bcd;
            r_disp_dp  <= r_pend_dp;
            r_pend     <= 1'b0;
        end else if (in_valid && !r_pend) begin
            r_pend_bcd <= in_bcd;
            r_pend_dp  <= in_dp;
            r_pend     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n       <= SEG_BLANK;
            r_dp_n        <= 1'b1;
            r_an_n        <= AN_OFF[NDIG-1:0];
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_slot0_start;
            if (w_blank) begin
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
                r_an_n  <= AN_OFF[NDIG-1:0];
            end else begin
                r_seg_n <= w_lz_sel ? SEG_BLANK : w_dec_seg_n;
                r_dp_n  <= !r_disp_dp[r_idx];
                r_an_n  <= w_an_sel_n;
            end
        end
    end

    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning number of multiplexed digits (1..8).
REQ-002 SHALL have parameter DIG_CYC, default 100000, meaning clocks each digit is selected per scan (>=4).
REQ-003 SHALL have parameter BLANK_CYC, default 2, meaning clocks at the start of each digit slot with all anodes off (< DIG_CYC).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  new display value offered.
REQ-007 SHALL have port in_ready  out  1  block can accept a value.
REQ-008 SHALL have port in_bcd  in  4*NDIG  digit codes; bits [3:0] = digit 0 (rightmost); within a nibble bit 0 = LSB.
REQ-009 SHALL have port in_dp  in  NDIG  decimal point per digit, 1 = lit.
REQ-010 SHALL have port seg_n  out  7  segments a..g on bits 0..6, active-low.
REQ-011 SHALL have port dp_n  out  1  decimal point, active-low.
REQ-012 SHALL have port an_n  out  NDIG  digit anodes, one-hot active-low.
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse when the digit 0 slot begins.

Function
REQ-014 SHALL transfer a value on a cycle where in_valid && in_ready, capturing in_bcd/in_dp into a pending register and setting the pending flag.
REQ-015 SHALL drive in_ready = !pending (combinational from a register); at most one value is pending.
REQ-016 SHALL copy pending into the display register only on the cycle the digit 0 slot begins (no tearing within a frame), clearing pending on that cycle; in_ready rises the following cycle.
REQ-017 SHALL keep pending and ignore in_valid while in_ready is low; the value offered then is not captured.
REQ-018 SHALL run a prescaler 0..DIG_CYC-1 and a digit index 0..NDIG-1; on prescaler wrap, index increments, wrapping NDIG-1 -> 0; frame_start pulses on the cycle index becomes 0 (including the first slot after reset).
REQ-019 SHALL drive an_n all-ones while prescaler < BLANK_CYC, otherwise bit [index] low only.
REQ-020 SHALL register seg_n/dp_n/an_n; outputs reflect the index and display register with exactly one clock latency.
REQ-021 SHALL decode codes 0-9 to standard patterns (0 = seg_n 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000) and codes 10-15 to blank (7'b1111111).
REQ-022 SHALL drive dp_n = !dp of the selected digit, forced 1 during blanking.

Reset
REQ-023 SHALL, while rst_n low: seg_n=7'h7F, dp_n=1, an_n all-ones, frame_start=0, prescaler=0, index=0, pending=0, display register all-zero codes with dp=0.
REQ-024 SHALL make in_ready high from the first clock after rst_n deasserts; reset mid-transfer discards pending without display update.

Configuration
REQ-025 SHALL, with LEADING_ZERO_BLANK_EN defined, blank (seg_n=7'h7F) every digit above digit 0 whose code is 0 and all higher digits are 0; dp unaffected.
REQ-026 SHALL, without LEADING_ZERO_BLANK_EN, display every zero digit normally.

Structure
REQ-027 SHALL place segment constants (SEG_BLANK, zero..nine patterns) and the anode-off constant in package bcd_scan_pkg.
REQ-028 SHALL instantiate one combinational sub-module bcd7seg_dec (4-bit code -> 7-bit active-low pattern, blank for 10-15).

Verification (NDIG=4, DIG_CYC=4, BLANK_CYC=1)
REQ-029 SHALL check reset: rst_n low -> seg_n=7'h7F, an_n=4'hF, in_ready=1 after release; frame_start at first slot.
REQ-030 SHALL check scan: load 16'h1234 -> after next frame_start, an_n cycles 4'hE,4'hD,4'hB,4'h7 with seg_n 4,3,2,1 patterns, one blank cycle per slot.
REQ-031 SHALL check handshake: load 16'h1111 then hold in_valid with 16'h2222 -> in_ready low until frame boundary, 2222 captured next, display never mixes digits within a frame.
REQ-032 SHALL check invalid codes: load 16'hFA98 -> digits 3,2 blank, digits 1,0 show 9,8.
REQ-033 SHALL check config: load 16'h0050 -> with LEADING_ZERO_BLANK_EN digits 3,2 blank, digits 1,0 show 5,0; without it, 0,0,5,0.
REQ-034 SHALL check async reset mid-frame with pending set -> outputs blank immediately, pending cleared, display all zeros.
